// File: rtl/phase_timer.sv
// phase_timer: programmable phase-duration timer with clamped load, capped extension, pause, abort and restart
module phase_timer #(
  parameter int WIDTH        = 8,
  parameter int MIN_TIME     = 10,
  parameter int DEFAULT_TIME = 20,
  parameter int EXT_STEP     = 5,
  parameter int MAX_TIME     = 60
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             load_en,
  input  logic [WIDTH-1:0] load_val,
  input  logic             extend,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             expired,
  output logic             ext_granted,
  output logic             ext_denied,
  output logic [WIDTH-1:0] elapsed,
  output logic [WIDTH-1:0] remaining
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [WIDTH-1:0] MIN_L = WIDTH'(MIN_TIME);
  localparam logic [WIDTH-1:0] DEF_L = WIDTH'(DEFAULT_TIME);
  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(MAX_TIME);
  state_t           state;
  logic [WIDTH-1:0] limit, load_lim, ext_lim, eff_lim;
  logic [WIDTH:0]   ext_sum, next_el;
  logic             ext_ok;
  // clamp the loaded duration, saturate the extended limit one bit wide so it never wraps
  always_comb begin
    load_lim = load_val < MIN_L ? MIN_L : (load_val > MAX_L ? MAX_L : load_val);
    ext_sum  = {1'b0, limit} + (WIDTH+1)'(EXT_STEP);
    ext_lim  = ext_sum > {1'b0, MAX_L} ? MAX_L : ext_sum[WIDTH-1:0];
    ext_ok   = extend && limit < MAX_L;
    eff_lim  = ext_ok ? ext_lim : limit;
    next_el  = {1'b0, elapsed} + (WIDTH+1)'(1);
  end
  // phase FSM: abort > start > extend > count; an extension granted on the expiry edge postpones expiry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      limit       <= '0;
      elapsed     <= '0;
      expired     <= 1'b0;
      ext_granted <= 1'b0;
      ext_denied  <= 1'b0;
    end else begin
      expired     <= 1'b0;
      ext_granted <= 1'b0;
      ext_denied  <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        limit   <= '0;
        elapsed <= '0;
      end else if (start) begin
        state   <= RUN;
        limit   <= load_en ? load_lim : DEF_L;
        elapsed <= '0;
      end else if (state == RUN) begin
        limit       <= eff_lim;
        ext_granted <= ext_ok;
        ext_denied  <= extend && !ext_ok;
        if (!pause) begin
          if (next_el >= {1'b0, eff_lim}) begin
            state   <= DONE;
            elapsed <= eff_lim;
            expired <= 1'b1;
          end else begin
            elapsed <= next_el[WIDTH-1:0];
          end
        end
      end
    end
  end
  assign busy      = state == RUN;
  assign done      = state == DONE;
  assign remaining = state == RUN ? limit - elapsed : '0;
endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer: directed and randomized checks of phase_timer against a behavioural model
module tb_phase_timer;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, load_en = 1'b0, extend = 1'b0, pause = 1'b0, abort = 1'b0;
  logic [7:0] load_val = '0;
  logic       busy, done, expired, ext_granted, ext_denied;
  logic [7:0] elapsed, remaining;

  phase_timer dut (
    .clk(clk), .rst(rst), .start(start), .load_en(load_en), .load_val(load_val),
    .extend(extend), .pause(pause), .abort(abort), .busy(busy), .done(done),
    .expired(expired), .ext_granted(ext_granted), .ext_denied(ext_denied),
    .elapsed(elapsed), .remaining(remaining)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  int m_run, m_done, m_exp, m_g, m_d, m_lim, m_el;
  int n, grants, denies;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_run = 0; m_done = 0; m_exp = 0; m_g = 0; m_d = 0; m_lim = 0; m_el = 0;
  endtask

  task automatic model_step();
    m_exp = 0; m_g = 0; m_d = 0;
    if (abort) begin
      m_run = 0; m_done = 0; m_lim = 0; m_el = 0;
    end else if (start) begin
      if (load_en) m_lim = load_val < 10 ? 10 : (load_val > 60 ? 60 : int'(load_val));
      else m_lim = 20;
      m_el = 0; m_run = 1; m_done = 0;
    end else if (m_run == 1) begin
      if (extend) begin
        if (m_lim < 60) begin
          m_lim = m_lim + 5 > 60 ? 60 : m_lim + 5;
          m_g = 1;
        end else m_d = 1;
      end
      if (!pause) begin
        if (m_el + 1 >= m_lim) begin
          m_run = 0; m_done = 1; m_el = m_lim; m_exp = 1;
        end else m_el++;
      end
    end
  endtask

  task automatic check_all();
    chk("busy", 32'(busy), m_run);
    chk("done", 32'(done), m_done);
    chk("expired", 32'(expired), m_exp);
    chk("ext_granted", 32'(ext_granted), m_g);
    chk("ext_denied", 32'(ext_denied), m_d);
    chk("elapsed", 32'(elapsed), m_el);
    chk("remaining", 32'(remaining), m_run == 1 ? m_lim - m_el : 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst) model_reset(); else model_step();
    #1;
    check_all();
  endtask

  task automatic tick(input logic s, input logic le, input logic [7:0] lv, input logic ex, input logic ab);
    start = s; load_en = le; load_val = lv; extend = ex; abort = ab;
    cycle();
    start = 1'b0; load_en = 1'b0; extend = 1'b0; abort = 1'b0;
  endtask

  task automatic wait_exp(input int max, output int cnt);
    cnt = 0;
    do begin
      cycle();
      cnt++;
    end while (!expired && cnt < max);
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    rst = 1'b1;
    repeat (2) cycle();
    // default duration
    tick(1, 0, 0, 0, 0);
    chk("start_remaining", 32'(remaining), 20);
    wait_exp(100, n);
    chk("default_expiry", n, 20);
    repeat (3) cycle();
    // clamped loads
    tick(1, 1, 8'd3, 0, 0);
    chk("clamp_low", 32'(remaining), 10);
    wait_exp(100, n);
    chk("clamp_low_expiry", n, 10);
    tick(1, 1, 8'd200, 0, 0);
    chk("clamp_high", 32'(remaining), 60);
    wait_exp(100, n);
    chk("clamp_high_expiry", n, 60);
    // extension on the would-be expiry edge
    tick(1, 0, 0, 0, 0);
    repeat (19) cycle();
    tick(0, 0, 0, 1, 0);
    chk("ext_on_expiry_grant", 32'(ext_granted), 1);
    chk("ext_on_expiry_noexp", 32'(expired), 0);
    wait_exp(100, n);
    chk("ext_expiry", 20 + n, 25);
    // eight extends from limit 30: six grants up to 60, then denials
    tick(1, 1, 8'd30, 0, 0);
    grants = 0; denies = 0;
    repeat (8) begin
      tick(0, 0, 0, 1, 0);
      grants += int'(ext_granted);
      denies += int'(ext_denied);
    end
    chk("ext_grants", grants, 6);
    chk("ext_denies", denies, 2);
    chk("ext_sat_remaining", 32'(remaining), 60 - 8);
    // pause for seven cycles
    tick(1, 0, 0, 0, 0);
    repeat (5) cycle();
    pause = 1'b1;
    repeat (7) cycle();
    chk("pause_hold", 32'(elapsed), 5);
    pause = 1'b0;
    wait_exp(100, n);
    chk("pause_expiry", 12 + n, 27);
    // abort mid-phase, and abort beating start and extend
    tick(1, 0, 0, 0, 0);
    repeat (12) cycle();
    tick(0, 0, 0, 0, 1);
    chk("abort_idle", 32'(busy), 0);
    tick(1, 0, 0, 0, 0);
    repeat (3) cycle();
    tick(1, 1, 8'd40, 1, 1);
    chk("abort_wins", 32'(elapsed), 0);
    // restart in DONE and in RUN
    tick(1, 1, 8'd10, 0, 0);
    wait_exp(100, n);
    cycle();
    tick(1, 0, 0, 0, 0);
    chk("restart_done_cleared", 32'(done), 0);
    repeat (8) cycle();
    tick(1, 1, 8'd15, 0, 0);
    chk("restart_run_elapsed", 32'(elapsed), 0);
    chk("restart_run_remaining", 32'(remaining), 15);
    // asynchronous reset mid-phase
    repeat (4) cycle();
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b1;
    repeat (2) cycle();
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      start = $urandom_range(0, 15) == 0;
      load_en = 1'($urandom_range(0, 1));
      load_val = 8'($urandom_range(0, 255));
      extend = $urandom_range(0, 5) == 0;
      abort = $urandom_range(0, 39) == 0;
      pause = $urandom_range(0, 3) == 0;
      cycle();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
